// File: rtl/ahb2apb_modport_bridge.sv
// AHB-Lite slave to APB master bridge.
// Each accepted AHB single transfer becomes one APB SETUP + ENABLE pair.
// HREADY is held low until the APB access finishes. The ENABLE cycle also
// serves as the next AHB address-phase slot, so transfers can run back to back.
module ahb2apb_modport_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              HRESET,
  input  logic              HSELAHB,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADY,
  output logic              HRESP,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic [DATA_W-1:0] PRDATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WWAIT,
    S_READ,
    S_RENABLE,
    S_WRITE,
    S_WENABLE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;

  // NONSEQ and SEQ both start a transfer; IDLE and BUSY are ignored
  logic valid;
  assign valid = HSELAHB & HTRANS[1];

  // Next-state and latch logic; address phase is only sampled while HREADY=1
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    case (state_q)
      S_IDLE, S_RENABLE, S_WENABLE: begin
        if (valid) begin
          addr_d  = HADDR;
          write_d = HWRITE;
          state_d = HWRITE ? S_WWAIT : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WWAIT: begin
        // HWDATA is valid one cycle after the write address phase
        wdata_d = HWDATA;
        state_d = S_WRITE;
      end
      S_READ:  state_d = S_RENABLE;
      S_WRITE: state_d = S_WENABLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and transfer registers; reset aborts any transfer in flight
  always_ff @(posedge clk) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  // Bus outputs decoded from the registered state and latched transfer
  always_comb begin
    HREADY  = 1'b1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    HRDATA  = '0;
    case (state_q)
      S_WWAIT: HREADY = 1'b0;
      S_READ: begin
        HREADY = 1'b0;
        PSEL   = 1'b1;
        PWRITE = write_q;
      end
      S_RENABLE: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = write_q;
        HRDATA  = PRDATA;
      end
      S_WRITE: begin
        HREADY = 1'b0;
        PSEL   = 1'b1;
        PWRITE = write_q;
      end
      S_WENABLE: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = write_q;
      end
      default: ;
    endcase
  end

  assign HRESP  = 1'b0;
  assign PADDR  = addr_q;
  assign PWDATA = wdata_q;

endmodule

// File: tb/tb_ahb2apb_modport_bridge.sv
// Bench for ahb2apb_modport_bridge: an AHB driver issues transfers and pushes
// the expected APB transaction into a scoreboard; a monitor on the APB side
// pops and compares when SETUP/ENABLE phases appear.
module tb_ahb2apb_modport_bridge;

  logic        clk = 1'b0;
  logic        HRESET;
  logic        HSELAHB;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;

  ahb2apb_modport_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .HRESET(HRESET), .HSELAHB(HSELAHB), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic logic [31:0] init_val(input int idx);
    return (idx == 8) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(idx));
  endfunction

  // Zero-wait APB slave: 64-word memory indexed by PADDR[7:2]
  logic [31:0] slave_mem [64];
  bit          mem_init = 1'b0;
  assign PRDATA = slave_mem[PADDR[7:2]];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) slave_mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (!HRESET && PSEL && PENABLE && PWRITE) begin
      slave_mem[PADDR[7:2]] <= PWDATA;
    end
  end

  // Reference model: what memory should hold after each committed write
  logic [31:0] ref_mem [64];

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          issue;
  } xfer_t;
  xfer_t sb[$];
  int    last_issue = 0;

  // Monitor: APB phases against the scoreboard front entry
  bit prev_setup = 1'b0;
  always @(negedge clk) begin : mon
    xfer_t f;
    if (HRESET === 1'b1) begin
      prev_setup = 1'b0;
    end else begin
      chk("hresp", 32'(HRESP), 32'd0);
      if (PSEL && !PENABLE) begin
        if (sb.size() == 0) chk("unexpected_setup", 32'd1, 32'd0);
        else begin
          f = sb[0];
          chk("setup_paddr", PADDR, f.addr);
          chk("setup_pwrite", 32'(PWRITE), 32'(f.wr));
          chk("setup_hready", 32'(HREADY), 32'd0);
          chk("setup_latency", 32'(cyc - f.issue), f.wr ? 32'd2 : 32'd1);
          if (f.wr) chk("setup_pwdata", PWDATA, f.wdata);
        end
        prev_setup = 1'b1;
      end else if (PSEL && PENABLE) begin
        chk("enable_after_setup", 32'(prev_setup), 32'd1);
        if (sb.size() == 0) chk("unexpected_enable", 32'd1, 32'd0);
        else begin
          f = sb.pop_front();
          chk("enable_paddr", PADDR, f.addr);
          chk("enable_pwrite", 32'(PWRITE), 32'(f.wr));
          chk("enable_hready", 32'(HREADY), 32'd1);
          chk("enable_latency", 32'(cyc - f.issue), f.wr ? 32'd3 : 32'd2);
          if (f.wr) chk("enable_pwdata", PWDATA, f.wdata);
          else      chk("read_hrdata", HRDATA, f.rdata);
        end
        prev_setup = 1'b0;
      end else begin
        chk("idle_penable", 32'(PENABLE), 32'd0);
        chk("idle_hrdata", HRDATA, 32'd0);
        prev_setup = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Non-transfer pattern while HREADY=1; anything at all while stalled
  task automatic drive_filler;
    int r;
    if (HREADY) begin
      r = $urandom_range(0, 2);
      HSELAHB = (r != 2);
      HTRANS  = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : 2'($urandom_range(2, 3));
    end else begin
      HSELAHB = 1'($urandom);
      HTRANS  = 2'($urandom);
    end
    HADDR  = $urandom;
    HWRITE = 1'($urandom);
    HWDATA = $urandom;
  endtask

  // Issue one transfer; returns in the cycle after its data phase begins
  task automatic ahb_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd, input bit commit);
    xfer_t x;
    int    guard;
    guard = 0;
    while (!HREADY && guard < 10) begin
      drive_filler();
      tick();
      guard++;
    end
    if (!HREADY) begin
      chk("hready_timeout", 32'(HREADY), 32'd1);
      return;
    end
    x.addr  = a;
    x.wr    = wr;
    x.wdata = wd;
    x.rdata = ref_mem[a[7:2]];
    x.issue = cyc;
    last_issue = cyc;
    if (wr && commit) ref_mem[a[7:2]] = wd;
    sb.push_back(x);
    HSELAHB = 1'b1;
    HTRANS  = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'd3;
    HADDR   = a;
    HWRITE  = wr;
    HWDATA  = $urandom;
    tick();
    // address-phase inputs are ignored while stalled: scramble them
    HSELAHB = 1'($urandom);
    HTRANS  = 2'($urandom);
    HADDR   = $urandom;
    HWRITE  = 1'($urandom);
    HWDATA  = wd;
    if (wr) tick();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive_filler();
      tick();
    end
  endtask

  initial begin : drv
    logic [31:0] a, d, saved;
    int rd_issue, guard;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    HRESET = 1'b1; HSELAHB = 1'b0; HTRANS = 2'd0; HADDR = '0;
    HWRITE = 1'b0; HWDATA = '0;
    repeat (2) @(posedge clk);
    #1 HRESET = 1'b0;
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);

    // single write, then single read of a preset word
    ahb_xfer(32'h10, 1'b1, 32'hDEAD_BEEF, 1'b1);
    idle(3);
    ahb_xfer(32'h20, 1'b0, '0, 1'b1);
    idle(3);

    // read followed by a write issued in the read's ENABLE cycle
    ahb_xfer(32'h20, 1'b0, '0, 1'b1);
    rd_issue = last_issue;
    ahb_xfer(32'h30, 1'b1, 32'hA5A5_0030, 1'b1);
    chk("b2b_no_idle", 32'(last_issue - rd_issue), 32'd2);
    idle(2);
    ahb_xfer(32'h30, 1'b0, '0, 1'b1);

    // ignored transfer types: bus must stay quiet
    idle(10);
    chk("ignored_hready", 32'(HREADY), 32'd1);
    chk("ignored_psel", 32'(PSEL), 32'd0);

    // random traffic, mixed gaps and back-to-back
    for (int k = 0; k < 200; k++) begin
      a = $urandom & 32'hFFFF_00FC;
      d = $urandom;
      ahb_xfer(a, 1'($urandom), d, 1'b1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    // reset during the WRITE setup cycle aborts the transfer
    idle(4);
    a = 32'h44;
    saved = ref_mem[a[7:2]];
    ahb_xfer(a, 1'b1, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
    #1;
    HRESET = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_psel", 32'(PSEL), 32'd0);
    chk("midrst_penable", 32'(PENABLE), 32'd0);
    chk("midrst_hready", 32'(HREADY), 32'd1);
    chk("midrst_paddr", PADDR, 32'd0);
    @(posedge clk);
    #1 HRESET = 1'b0;
    idle(4);
    chk("midrst_ref_kept", ref_mem[a[7:2]], saved);
    ahb_xfer(a, 1'b0, '0, 1'b1);
    idle(3);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
